// File: rtl/mc_main_control_if.sv
// mc_if: controller-to-datapath bundle for the multicycle MIPS main control FSM
interface mc_if #(
    parameter int OPW = 6,
    parameter int SW  = 4
);
    logic [OPW-1:0] op;
    logic           zero;
    logic           mem_ready;
    logic           pcen;
    logic           iord;
    logic           memread;
    logic           memwrite;
    logic           irwrite;
    logic           memtoreg;
    logic           regdst;
    logic           regwrite;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     pcsource;
    logic           aluop2;
    logic           aluop1;
    logic           aluop0;
    logic           illegal_op;
    logic [SW-1:0]  state;

    modport master (
        input  op, zero, mem_ready,
        output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsource, aluop2, aluop1, aluop0, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsource, aluop2, aluop1, aluop0, illegal_op, state
    );
endinterface

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main controller FSM driving datapath muxes, enables and ALUOp
module mc_main_control #(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input logic clk,
    input logic rst_n,
    mc_if.master bus
);
    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    typedef enum logic [SW-1:0] {
        FETCH  = SW'(0),
        DECODE = SW'(1),
        MEMADR = SW'(2),
        MEMRD  = SW'(3),
        MEMWB  = SW'(4),
        MEMWR  = SW'(5),
        REXEC  = SW'(6),
        RWB    = SW'(7),
        BRANCH = SW'(8),
        IEXEC  = SW'(9),
        IWB    = SW'(10),
        JUMP   = SW'(11)
    } state_t;

    state_t     st;
    logic       illegal;
    logic [2:0] aluop;
    logic       is_r, is_mem, is_sw, is_beq, is_bne, is_imm, is_andi, is_ori, is_j;

    assign is_r    = bus.op == OP_R;
    assign is_sw   = bus.op == OP_SW;
    assign is_mem  = bus.op == OP_LW || is_sw;
    assign is_beq  = bus.op == OP_BEQ;
    assign is_bne  = bus.op == OP_BNE;
    assign is_andi = bus.op == OP_ANDI;
    assign is_ori  = bus.op == OP_ORI;
    assign is_imm  = bus.op == OP_ADDI || is_andi || is_ori;
    assign is_j    = bus.op == OP_J;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st      <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (st)
                FETCH:  st <= bus.mem_ready ? DECODE : FETCH;
                DECODE: begin
                    st <= is_mem ? MEMADR : is_r ? REXEC : (is_beq || is_bne) ? BRANCH :
                          is_imm ? IEXEC : is_j ? JUMP : FETCH;
                    if (!(is_mem || is_r || is_beq || is_bne || is_imm || is_j)) illegal <= 1'b1;
                end
                MEMADR: st <= is_sw ? MEMWR : MEMRD;
                MEMRD:  st <= bus.mem_ready ? MEMWB : MEMRD;
                MEMWR:  st <= bus.mem_ready ? FETCH : MEMWR;
                REXEC:  st <= RWB;
                IEXEC:  st <= IWB;
                default: st <= FETCH;
            endcase
        end

    // Moore decode of the state register; only pcen/irwrite look at mem_ready or zero
    always_comb begin
        bus.pcen     = 1'b0;
        bus.iord     = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsource = 2'b00;
        aluop        = 3'b000;
        case (st)
            FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcen    = bus.mem_ready;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEMWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            REXEC: begin
                bus.alusrca = 1'b1;
                aluop       = 3'b010;
            end
            RWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            BRANCH: begin
                bus.alusrca  = 1'b1;
                bus.pcsource = 2'b01;
                aluop        = 3'b001;
                bus.pcen     = is_beq ? bus.zero : is_bne & ~bus.zero;
            end
            IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                aluop       = is_andi ? 3'b101 : is_ori ? 3'b100 : 3'b000;
            end
            IWB: bus.regwrite = 1'b1;
            JUMP: begin
                bus.pcsource = 2'b10;
                bus.pcen     = 1'b1;
            end
            default: ;
        endcase
    end

    assign {bus.aluop2, bus.aluop1, bus.aluop0} = aluop;
    assign bus.illegal_op = illegal;
    assign bus.state      = st;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: scoreboard bench; driver queues expected per-cycle outputs, negedge monitor compares
module tb_mc_main_control;
    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic [2:0] aluop;
        logic       ill;
    } vec_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, ANDI = 6'b001100, ORI = 6'b001101, J = 6'b000010,
                           BAD = 6'b111111;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    vec_t  q[$];
    string lq[$];
    int    checks = 0;
    int    passed = 0;

    mc_if #(.OPW(6), .SW(4)) bus ();
    mc_main_control #(.OPW(6), .SW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic vec_t base(input logic [3:0] s);
        vec_t v = '0;
        v.st = s;
        case (s)
            4'd0: begin v.memread = 1; v.alusrcb = 2'b01; end
            4'd1: v.alusrcb = 2'b11;
            4'd2: begin v.alusrca = 1; v.alusrcb = 2'b10; end
            4'd3: begin v.memread = 1; v.iord = 1; end
            4'd4: begin v.regwrite = 1; v.memtoreg = 1; end
            4'd5: begin v.memwrite = 1; v.iord = 1; end
            4'd6: v.alusrca = 1;
            4'd7: begin v.regwrite = 1; v.regdst = 1; end
            4'd8: begin v.alusrca = 1; v.pcsource = 2'b01; end
            4'd9: begin v.alusrca = 1; v.alusrcb = 2'b10; end
            4'd10: v.regwrite = 1;
            4'd11: v.pcsource = 2'b10;
            default: ;
        endcase
        return v;
    endfunction

    function automatic vec_t actual();
        vec_t v;
        v.st = bus.state; v.pcen = bus.pcen; v.iord = bus.iord; v.memread = bus.memread;
        v.memwrite = bus.memwrite; v.irwrite = bus.irwrite; v.memtoreg = bus.memtoreg;
        v.regdst = bus.regdst; v.regwrite = bus.regwrite; v.alusrca = bus.alusrca;
        v.alusrcb = bus.alusrcb; v.pcsource = bus.pcsource;
        v.aluop = {bus.aluop2, bus.aluop1, bus.aluop0}; v.ill = bus.illegal_op;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One cycle of stimulus plus the hand-computed response for that cycle
    task automatic step(input string name, input logic rdy, input logic z, input logic [5:0] o,
                        input logic [3:0] s, input logic pc, input logic ir,
                        input logic [2:0] aop, input logic ill);
        vec_t e;
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        bus.zero = z;
        bus.op = o;
        e = base(s);
        e.pcen = pc;
        e.irwrite = ir;
        e.aluop = aop;
        e.ill = ill;
        q.push_back(e);
        lq.push_back(name);
    endtask

    always @(negedge clk)
        if (q.size() > 0) check(lq.pop_front(), 32'(actual()), 32'(q.pop_front()));

    initial begin
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.op = R;
        repeat (3) step("rst_hold", 0, 0, R, 0, 0, 0, 3'b000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("lw_fetch", 1, 0, LW, 0, 1, 1, 3'b000, 0);
        step("lw_dec", 1, 0, LW, 1, 0, 0, 3'b000, 0);
        step("lw_adr", 1, 0, LW, 2, 0, 0, 3'b000, 0);
        step("lw_rd_w1", 0, 0, LW, 3, 0, 0, 3'b000, 0);
        step("lw_rd_w2", 0, 0, LW, 3, 0, 0, 3'b000, 0);
        step("lw_rd", 1, 0, LW, 3, 0, 0, 3'b000, 0);
        step("lw_wb", 1, 0, LW, 4, 0, 0, 3'b000, 0);
        step("beq_fetch", 1, 1, BEQ, 0, 1, 1, 3'b000, 0);
        step("beq_dec", 1, 1, BEQ, 1, 0, 0, 3'b000, 0);
        step("beq_br", 1, 1, BEQ, 8, 1, 0, 3'b001, 0);
        step("bne_fetch", 1, 1, BNE, 0, 1, 1, 3'b000, 0);
        step("bne_dec", 1, 1, BNE, 1, 0, 0, 3'b000, 0);
        step("bne_br", 1, 1, BNE, 8, 0, 0, 3'b001, 0);
        step("andi_fetch", 1, 0, ANDI, 0, 1, 1, 3'b000, 0);
        step("andi_dec", 1, 0, ANDI, 1, 0, 0, 3'b000, 0);
        step("andi_ex", 1, 0, ANDI, 9, 0, 0, 3'b101, 0);
        step("andi_wb", 1, 0, ANDI, 10, 0, 0, 3'b000, 0);
        step("ori_fetch", 1, 0, ORI, 0, 1, 1, 3'b000, 0);
        step("ori_dec", 1, 0, ORI, 1, 0, 0, 3'b000, 0);
        step("ori_ex", 1, 0, ORI, 9, 0, 0, 3'b100, 0);
        step("ori_wb", 1, 0, ORI, 10, 0, 0, 3'b000, 0);
        step("r_fetch", 1, 0, R, 0, 1, 1, 3'b000, 0);
        step("r_dec", 1, 0, R, 1, 0, 0, 3'b000, 0);
        step("r_ex", 1, 0, R, 6, 0, 0, 3'b010, 0);
        step("r_wb", 1, 0, R, 7, 0, 0, 3'b000, 0);
        step("sw_fetch", 1, 0, SW, 0, 1, 1, 3'b000, 0);
        step("sw_dec", 1, 0, SW, 1, 0, 0, 3'b000, 0);
        step("sw_adr", 1, 0, SW, 2, 0, 0, 3'b000, 0);
        step("sw_wr_wait", 0, 0, SW, 5, 0, 0, 3'b000, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), 32'd0);
        check("async_rst_memwrite", 32'(bus.memwrite), 32'd0);
        check("async_rst_regwrite", 32'(bus.regwrite), 32'd0);
        step("rst_mid", 0, 0, J, 0, 0, 0, 3'b000, 0);
        rst_n = 1'b1;
        step("post_rst1", 0, 0, J, 0, 0, 0, 3'b000, 0);
        step("post_rst2", 0, 0, J, 0, 0, 0, 3'b000, 0);
        step("j_fetch", 1, 0, J, 0, 1, 1, 3'b000, 0);
        step("j_dec", 1, 0, J, 1, 0, 0, 3'b000, 0);
        step("j_jump", 1, 0, J, 11, 1, 0, 3'b000, 0);
        step("bad_fetch", 1, 0, BAD, 0, 1, 1, 3'b000, 0);
        step("bad_dec", 1, 0, BAD, 1, 0, 0, 3'b000, 0);
        step("bad_refetch", 1, 0, R, 0, 1, 1, 3'b000, 1);
        step("add_dec", 1, 0, R, 1, 0, 0, 3'b000, 1);
        step("add_ex", 1, 0, R, 6, 0, 0, 3'b010, 1);
        step("add_wb", 1, 0, R, 7, 0, 0, 3'b000, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ill_clear", 32'(bus.illegal_op), 32'd0);
        step("rst_end", 0, 0, R, 0, 0, 0, 3'b000, 0);
        rst_n = 1'b1;
        step("idle_end", 0, 0, R, 0, 0, 0, 3'b000, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
